// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between the round-robin arbiter and its requesters / mux consumer.
// The slave side is the arbiter itself; the master side drives requests and data.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       w;
  logic       w_valid;
  logic       busy;

  modport master (
    output req, a, b, c, d,
    input  s0, s1, gnt, w, w_valid, busy
  );

  modport slave (
    input  req, a, b, c, d,
    output s0, s1, gnt, w, w_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters. Drives the
// mux selects from the grant and registers the selected data bit with a
// valid flag that lags the grant by one cycle.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.slave bus
);

  localparam int unsigned HOLD_W = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              w_q;
  logic              w_valid_q;

  logic [3:0]        others;
  logic [1:0]        idle_win;
  logic [1:0]        next_win;
  logic              mux_bit;

  // First set bit of r, searching upward from index start with wrap.
  function automatic logic [1:0] scan_from(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    scan_from = start;
    found     = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        scan_from = idx;
        found     = 1'b1;
      end
    end
  endfunction

  // While granting, gnt_q is the owner's one-hot, so masking it leaves the
  // competing requests; scanning from owner+1 visits the owner last.
  assign others   = bus.req & ~gnt_q;
  assign idle_win = scan_from(bus.req, last_q + 2'd1);
  assign next_win = scan_from(others, sel_q + 2'd1);

  // Mux datapath using the currently driven selects.
  always_comb begin
    mux_bit = bus.a;
    case (sel_q)
      2'd0: mux_bit = bus.a;
      2'd1: mux_bit = bus.b;
      2'd2: mux_bit = bus.c;
      2'd3: mux_bit = bus.d;
      default: mux_bit = bus.a;
    endcase
  end

  // Next-state decision: idle pick-up, release, forced rotation at MAX_HOLD.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << idle_win;
          sel_d   = idle_win;
          last_d  = idle_win;
          hold_d  = HOLD_W'(1);
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          if (|others) begin
            gnt_d  = 4'b0001 << next_win;
            sel_d  = next_win;
            last_d = next_win;
            hold_d = HOLD_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
          if (|others) begin
            gnt_d  = 4'b0001 << next_win;
            sel_d  = next_win;
            last_d = next_win;
          end
          hold_d = HOLD_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= 2'd3;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      w_q       <= mux_bit;
      w_valid_q <= (state_q == GRANT);
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s1      = sel_q[1];
  assign bus.s0      = sel_q[0];
  assign bus.w       = w_q;
  assign bus.w_valid = w_valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a queue-free behavioural model.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] data;   // {d,c,b,a}
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       w;
    logic       wv;
    logic       busy;
  } vec_t;

  vec_t vecs [10];

  // Behavioural model state: who owns the mux, for how long, who went last.
  bit         m_grant;
  int         m_owner;
  int         m_last;
  int         m_cnt;
  logic [1:0] m_sel;
  logic       m_w;
  logic       m_wv;

  function automatic logic [8:0] dut_vec();
    return {bus.gnt, bus.s1, bus.s0, bus.w, bus.w_valid, bus.busy};
  endfunction

  function automatic logic [8:0] model_vec();
    logic [3:0] g;
    g = m_grant ? 4'(1 << m_owner) : 4'b0000;
    return {g, m_sel, m_w, m_wv, logic'(m_grant)};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b (gnt,s1s0,w,w_valid,busy)", name, act, exp);
    else
      passed++;
  endtask

  // Round-robin rule: first requester strictly after k, wrapping, k itself last.
  function automatic int next_after(input int k, input logic [3:0] r);
    for (int j = 1; j <= 4; j++)
      if (r[(k + j) % 4]) return (k + j) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_grant = 0; m_owner = 0; m_last = 3; m_cnt = 0;
    m_sel = 2'd0; m_w = 1'b0; m_wv = 1'b0;
  endtask

  task automatic model_take(input int n);
    m_grant = 1; m_owner = n; m_last = n; m_cnt = 1; m_sel = 2'(n);
  endtask

  task automatic model_step();
    logic [3:0] dat;
    logic [3:0] oth;
    logic       nw;
    logic       nwv;
    dat = {bus.d, bus.c, bus.b, bus.a};
    nw  = dat[m_sel];
    nwv = m_grant;
    if (!m_grant) begin
      if (bus.req != 4'b0000) model_take(next_after(m_last, bus.req));
    end else begin
      oth = bus.req & ~4'(1 << m_owner);
      if (!bus.req[m_owner]) begin
        if (oth != 4'b0000) model_take(next_after(m_owner, oth));
        else m_grant = 0;
      end else if (m_cnt == MAXH) begin
        if (oth != 4'b0000) model_take(next_after(m_owner, oth));
        else m_cnt = 1;
      end else begin
        m_cnt++;
      end
    end
    m_w  = nw;
    m_wv = nwv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    {bus.d, bus.c, bus.b, bus.a} = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    total  = 0;
    passed = 0;

    // Directed per-cycle vectors, starting right after reset release.
    vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0};

    // Reset held with all requests asserted and clock running.
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    {bus.d, bus.c, bus.b, bus.a} = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("reset_hold", dut_vec(), 9'b0);
    end
    bus.req = 4'b0000;
    {bus.d, bus.c, bus.b, bus.a} = 4'b0000;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      bus.req = vecs[i].req;
      {bus.d, bus.c, bus.b, bus.a} = vecs[i].data;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), dut_vec(),
            {vecs[i].gnt, vecs[i].sel, vecs[i].w, vecs[i].wv, vecs[i].busy});
    end

    // All four requesting: each owner holds exactly MAXH cycles, no gap.
    bus.req = 4'b1111;
    {bus.d, bus.c, bus.b, bus.a} = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("rotate_c%0d", i), {bus.gnt, bus.s1, bus.s0, 3'b000},
            {4'(1 << ((i / MAXH) % 4)), 2'((i / MAXH) % 4), 3'b000});
    end

    // Lone requester keeps the mux past MAXH.
    bus.req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("lone_c%0d", i), {bus.gnt, 5'b0}, {4'b0001, 5'b0});
    end
    bus.req = 4'b0101;
    found = 0;
    for (int i = 0; i < MAXH && !found; i++) begin
      @(posedge clk); #1;
      if (bus.gnt == 4'b0100) found = 1;
    end
    check("late_req_rotation", 9'(found), 9'd1);

    // Move to owner 3, then pulse reset between edges.
    bus.req = 4'b1000;
    @(posedge clk); #1;
    check("owner3", {bus.gnt, bus.s1, bus.s0, 3'b0}, {4'b1000, 2'd3, 3'b0});
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), 9'b0);
    #1 rst_n = 1'b1;
    bus.req = 4'b0110;
    @(posedge clk); #1;
    check("post_reset_first", {bus.gnt, bus.s1, bus.s0, 3'b0}, {4'b0010, 2'd1, 3'b0});

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      {bus.d, bus.c, bus.b, bus.a} = 4'($urandom_range(0, 15));
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand_c%0d", i), dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
